// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_sequencer
// Description : Multi-cycle RV32I control FSM (fetch/decode/exec/mem/wb),
//               owning pc, ir and instret. Optional macro: TRAP_ILLEGAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef TRAP_ILLEGAL_EN
  ,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
`endif
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        decode_en,
  output logic        alu_en,
  input  logic [31:0] alu_result,
  input  logic        branch_taken,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic [1:0]  rf_wsel,
  output logic [31:0] pc,
  output logic        retire,
  output logic [31:0] instret,
  output logic        illegal_insn
);

  localparam logic [6:0]  c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0]  c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  c_OPC_OP     = 7'b0110011;
  localparam logic [6:0]  c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  c_OPC_JALR   = 7'b1100111;
  localparam logic [31:0] c_NOP        = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
`ifdef TRAP_ILLEGAL_EN
    ,
    S_TRAP   = 3'd6
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] instret_q;

  logic [6:0]  w_opcode;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_j;
  logic [31:0] w_pc_plus4;

  assign w_opcode   = ir_q[6:0];
  assign w_imm_b    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign w_imm_j    = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign w_pc_plus4 = pc_q + 32'd4;

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign instret   = instret_q;

  // All strobes and requests decode from state so an async reset drops them at once.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    imem_req     = 1'b0;
    decode_en    = 1'b0;
    alu_en       = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    rf_we        = 1'b0;
    rf_wsel      = 2'b00;
    retire       = 1'b0;
    illegal_insn = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        decode_en = 1'b1;
        state_d   = S_EXEC;
      end
      S_EXEC: begin
        alu_en = 1'b1;
        case (w_opcode)
          c_OPC_LOAD, c_OPC_STORE: state_d = S_MEM;
          c_OPC_BRANCH: begin
            state_d = S_FETCH;
            pc_d    = branch_taken ? (pc_q + w_imm_b) : w_pc_plus4;
            retire  = 1'b1;
          end
          c_OPC_LUI, c_OPC_AUIPC, c_OPC_OP_IMM, c_OPC_OP,
          c_OPC_JAL, c_OPC_JALR: state_d = S_WB;
          default: begin
`ifdef TRAP_ILLEGAL_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
            pc_d    = w_pc_plus4;
            retire  = 1'b1;
`endif
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (w_opcode == c_OPC_STORE);
        if (dmem_ready) begin
          if (w_opcode == c_OPC_STORE) begin
            state_d = S_FETCH;
            pc_d    = w_pc_plus4;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        case (w_opcode)
          c_OPC_LOAD: begin
            rf_wsel = 2'b01;
            pc_d    = w_pc_plus4;
          end
          c_OPC_JAL: begin
            rf_wsel = 2'b10;
            pc_d    = pc_q + w_imm_j;
          end
          c_OPC_JALR: begin
            rf_wsel = 2'b10;
            pc_d    = alu_result & 32'hFFFF_FFFE;
          end
          default: begin
            rf_wsel = 2'b00;
            pc_d    = w_pc_plus4;
          end
        endcase
      end
`ifdef TRAP_ILLEGAL_EN
      S_TRAP: begin
        illegal_insn = 1'b1;
        pc_d         = TRAP_VECTOR;
        state_d      = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= c_NOP;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      if (retire) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_sequencer
// Description : Self-checking bench: directed table, random stream vs model,
//               and reset-during-memory-wait sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        decode_en;
  logic        alu_en;
  logic [31:0] alu_result;
  logic        branch_taken;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        rf_we;
  logic [1:0]  rf_wsel;
  logic [31:0] pc;
  logic        retire;
  logic [31:0] instret;
  logic        illegal_insn;

  core_sequencer dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ir(ir), .decode_en(decode_en), .alu_en(alu_en),
    .alu_result(alu_result), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .pc(pc), .retire(retire),
    .instret(instret), .illegal_insn(illegal_insn)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cycles;
    logic [31:0] npc;
    int          rfwe;
    int          wsel;
    int          dm;
    int          dmwe;
    int          ret;
    int          ill;
  } exp_t;

  typedef struct {
    logic [31:0] insn;
    logic [31:0] alu;
    logic        tk;
    int          iw;
    int          dw;
    exp_t        e;
  } vec_t;

  typedef struct {
    int          cycles;
    logic [31:0] addr0;
    int          addr_bad;
    int          dec_n;
    int          alu_n;
    int          rfwe_n;
    int          wsel;
    int          dm_n;
    int          dmwe;
    int          dmwe_bad;
    int          ret_n;
    int          ill_n;
    logic [31:0] ir_seen;
  } obs_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instret;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  function automatic exp_t mk_e(int cyc, logic [31:0] npc, int rfwe, int wsel, int dm, int dmwe, int ret, int ill);
    exp_t e;
    e.cycles = cyc; e.npc = npc; e.rfwe = rfwe; e.wsel = wsel;
    e.dm = dm; e.dmwe = dmwe; e.ret = ret; e.ill = ill;
    return e;
  endfunction

  function automatic vec_t mkv(logic [31:0] insn, logic [31:0] alu, logic tk, int iw, int dw, exp_t e);
    vec_t v;
    v.insn = insn; v.alu = alu; v.tk = tk; v.iw = iw; v.dw = dw; v.e = e;
    return v;
  endfunction

  // Reference model: cycle cost and next pc straight from the instruction-class rules.
  function automatic exp_t model(logic [31:0] cur_pc, logic [31:0] insn, logic [31:0] alu,
                                 logic tk, int iw, int dw);
    exp_t e;
    int immb, immj;
    immb = (insn[31] ? -4096 : 0) + int'(insn[7]) * 2048 + int'(insn[30:25]) * 32 + int'(insn[11:8]) * 2;
    immj = (insn[31] ? -1048576 : 0) + int'(insn[19:12]) * 4096 + int'(insn[20]) * 2048 + int'(insn[30:21]) * 2;
    e = mk_e(4 + iw, cur_pc + 32'd4, 1, 0, 0, 0, 1, 0);
    case (insn[6:0])
      7'h63: begin
        e.cycles = 3 + iw; e.rfwe = 0;
        e.npc = tk ? cur_pc + 32'(immb) : cur_pc + 32'd4;
      end
      7'h03: begin e.cycles = 5 + iw + dw; e.wsel = 1; e.dm = dw + 1; end
      7'h23: begin e.cycles = 4 + iw + dw; e.rfwe = 0; e.dm = dw + 1; e.dmwe = 1; end
      7'h6F: begin e.wsel = 2; e.npc = cur_pc + 32'(immj); end
      7'h67: begin e.wsel = 2; e.npc = {alu[31:1], 1'b0}; end
      7'h37, 7'h17, 7'h13, 7'h33: ;
      default: begin
        e.rfwe = 0;
`ifdef TRAP_ILLEGAL_EN
        e.cycles = 4 + iw; e.npc = 32'h0000_0100; e.ret = 0; e.ill = 1;
`else
        e.cycles = 3 + iw;
`endif
      end
    endcase
    return e;
  endfunction

  // Called at a clock low phase with the DUT in its first FETCH cycle.
  task automatic run_insn(input logic [31:0] insn, input logic [31:0] alu, input logic tk,
                          input int iw, input int dw, output obs_t o);
    int   cyc, icnt, dcnt;
    logic prev, done, first_we;
    o = '{default: 0};
    cyc = 0; icnt = 0; dcnt = 0; prev = 1'b0; done = 1'b0; first_we = 1'b1;
    while (!done && cyc < 80) begin
      alu_result   = alu;
      branch_taken = tk;
      if (imem_req) begin
        imem_ready = (icnt == iw); imem_rdata = insn; icnt++;
      end else begin
        imem_ready = 1'($urandom_range(0, 1)); imem_rdata = $urandom;
      end
      if (dmem_req) begin
        dmem_ready = (dcnt == dw); dcnt++;
      end else begin
        dmem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      if (cyc > 0 && imem_req && !prev) begin
        done = 1'b1;
      end else begin
        if (cyc == 0) o.addr0 = imem_addr;
        if (imem_req && imem_addr !== o.addr0) o.addr_bad++;
        if (decode_en) o.dec_n++;
        if (alu_en) o.alu_n++;
        if (rf_we) begin o.rfwe_n++; o.wsel = int'(rf_wsel); end
        if (dmem_req) begin
          if (!first_we && o.dmwe != int'(dmem_we)) o.dmwe_bad++;
          o.dm_n++; o.dmwe = int'(dmem_we); first_we = 1'b0;
        end
        if (retire) o.ret_n++;
        if (illegal_insn) o.ill_n++;
        prev = imem_req;
        cyc++;
        @(posedge clk);
        @(negedge clk);
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL timeout: no return to fetch after %0d cycles", cyc);
      finish_run();
    end
    o.cycles  = cyc;
    o.ir_seen = ir;
  endtask

  task automatic check_obs(input string tag, input int idx, input logic [31:0] insn,
                           input exp_t e, input obs_t o);
    string p;
    p = $sformatf("%s[%0d]", tag, idx);
    chk({p, " fetch_addr"}, o.addr0, m_pc);
    chk({p, " addr_stable"}, o.addr_bad, 0);
    chk({p, " ir"}, o.ir_seen, insn);
    chk({p, " cycles"}, o.cycles, e.cycles);
    chk({p, " decode_en"}, o.dec_n, 1);
    chk({p, " alu_en"}, o.alu_n, 1);
    chk({p, " rf_we"}, o.rfwe_n, e.rfwe);
    if (e.rfwe != 0) chk({p, " rf_wsel"}, o.wsel, e.wsel);
    chk({p, " dmem_cycles"}, o.dm_n, e.dm);
    if (e.dm != 0) begin
      chk({p, " dmem_we"}, o.dmwe, e.dmwe);
      chk({p, " dmem_we_stable"}, o.dmwe_bad, 0);
    end
    chk({p, " retire"}, o.ret_n, e.ret);
    chk({p, " illegal"}, o.ill_n, e.ill);
    chk({p, " pc"}, pc, e.npc);
    chk({p, " instret"}, instret, m_instret);
  endtask

  vec_t tbl[$];
  logic [6:0] ops[11] = '{7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h13, 7'h33, 7'h6F, 7'h67, 7'h7F, 7'h0B};

  initial begin
    obs_t o;
    exp_t e;
    logic [31:0] r, insn, alu;
    int n;

    tbl.push_back(mkv(32'h0050_0093, 32'h5,        1'b0, 0, 0, mk_e(4, 32'h4,   1, 0, 0, 0, 1, 0)));
    tbl.push_back(mkv(32'h0000_A103, 32'h100,      1'b0, 0, 3, mk_e(8, 32'h8,   1, 1, 4, 0, 1, 0)));
    tbl.push_back(mkv(32'h0000_80E7, 32'h20,       1'b0, 0, 0, mk_e(4, 32'h20,  1, 2, 0, 0, 1, 0)));
    tbl.push_back(mkv(32'hFE00_0CE3, 32'h0,        1'b1, 0, 0, mk_e(3, 32'h18,  0, 0, 0, 0, 1, 0)));
    tbl.push_back(mkv(32'h0000_80E7, 32'h21,       1'b0, 0, 0, mk_e(4, 32'h20,  1, 2, 0, 0, 1, 0)));
    tbl.push_back(mkv(32'hFE00_0CE3, 32'h0,        1'b0, 0, 0, mk_e(3, 32'h24,  0, 0, 0, 0, 1, 0)));
    tbl.push_back(mkv(32'h0000_80E7, 32'h40,       1'b0, 0, 0, mk_e(4, 32'h40,  1, 2, 0, 0, 1, 0)));
    tbl.push_back(mkv(32'h1000_00EF, 32'h0,        1'b0, 0, 0, mk_e(4, 32'h140, 1, 2, 0, 0, 1, 0)));
    tbl.push_back(mkv(32'h0000_80E7, 32'h203,      1'b0, 0, 0, mk_e(4, 32'h202, 1, 2, 0, 0, 1, 0)));
    tbl.push_back(mkv(32'h0020_A023, 32'h300,      1'b0, 0, 0, mk_e(4, 32'h206, 0, 0, 1, 1, 1, 0)));
    tbl.push_back(mkv(32'h0020_A023, 32'h300,      1'b0, 1, 2, mk_e(7, 32'h20A, 0, 0, 3, 1, 1, 0)));
    tbl.push_back(mkv(32'h1234_50B7, 32'h0,        1'b0, 2, 0, mk_e(6, 32'h20E, 1, 0, 0, 0, 1, 0)));
`ifdef TRAP_ILLEGAL_EN
    tbl.push_back(mkv(32'h0000_007F, 32'h0,        1'b0, 0, 0, mk_e(4, 32'h100, 0, 0, 0, 0, 0, 1)));
`else
    tbl.push_back(mkv(32'h0000_007F, 32'h0,        1'b0, 0, 0, mk_e(3, 32'h212, 0, 0, 0, 0, 1, 0)));
`endif
    tbl.push_back(mkv(32'h0000_80E7, 32'hFFFF_FFFC, 1'b0, 0, 0, mk_e(4, 32'hFFFF_FFFC, 1, 2, 0, 0, 1, 0)));
    tbl.push_back(mkv(32'h0000_1097, 32'h0,        1'b0, 0, 0, mk_e(4, 32'h0,   1, 0, 0, 0, 1, 0)));
    tbl.push_back(mkv(32'h0020_81B3, 32'h0,        1'b0, 0, 0, mk_e(4, 32'h4,   1, 0, 0, 0, 1, 0)));
    tbl.push_back(mkv(32'h0000_0463, 32'h0,        1'b1, 0, 0, mk_e(3, 32'hC,   0, 0, 0, 0, 1, 0)));
    tbl.push_back(mkv(32'h0000_0463, 32'h0,        1'b1, 3, 0, mk_e(6, 32'h14,  0, 0, 0, 0, 1, 0)));
    tbl.push_back(mkv(32'h0000_A103, 32'h0,        1'b0, 0, 0, mk_e(5, 32'h18,  1, 1, 1, 0, 1, 0)));

    rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; alu_result = 32'h0;
    branch_taken = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset pc", pc, 32'h0);
    chk("reset ir", ir, 32'h0000_0013);
    chk("reset instret", instret, 32'h0);
    chk("reset rf_wsel", 32'(rf_wsel), 32'h0);
    chk("reset strobes", {imem_req, decode_en, alu_en, dmem_req, rf_we, retire, illegal_insn}, 32'h0);
    rst = 1'b0;
    #1;
    chk("idle imem_req", 32'(imem_req), 32'h0);
    @(posedge clk);
    @(negedge clk);
    m_pc = 32'h0;
    m_instret = 32'h0;

    foreach (tbl[i]) begin
      run_insn(tbl[i].insn, tbl[i].alu, tbl[i].tk, tbl[i].iw, tbl[i].dw, o);
      m_instret += 32'(tbl[i].e.ret);
      check_obs("dir", i, tbl[i].insn, tbl[i].e, o);
      m_pc = tbl[i].e.npc;
    end

    for (int k = 0; k < 150; k++) begin
      r    = $urandom;
      insn = {r[31:7], ops[$urandom_range(0, 10)]};
      alu  = $urandom;
      e    = model(m_pc, insn, alu, 1'($urandom_range(0, 1)), 0, 0);
      begin
        logic tk;
        int   iw, dw;
        tk = 1'($urandom_range(0, 1));
        iw = $urandom_range(0, 3);
        dw = $urandom_range(0, 3);
        e  = model(m_pc, insn, alu, tk, iw, dw);
        run_insn(insn, alu, tk, iw, dw, o);
      end
      m_instret += 32'(e.ret);
      check_obs("rnd", k, insn, e, o);
      m_pc = e.npc;
    end

    // Reset while a load sits in its memory wait.
    imem_ready = 1'b1; imem_rdata = 32'h0000_A103; dmem_ready = 1'b0;
    n = 0;
    while (!dmem_req && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("rstmem reach_mem", 32'(dmem_req), 32'h1);
    @(posedge clk);
    @(negedge clk);
    chk("rstmem holding", 32'(dmem_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rstmem dmem_req", 32'(dmem_req), 32'h0);
    chk("rstmem retire", 32'(retire), 32'h0);
    chk("rstmem rf_we", 32'(rf_we), 32'h0);
    chk("rstmem pc", pc, 32'h0);
    chk("rstmem instret", instret, 32'h0);
    chk("rstmem ir", ir, 32'h0000_0013);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmem idle", 32'(imem_req), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rstmem refetch", 32'(imem_req), 32'h1);
    chk("rstmem refetch addr", imem_addr, 32'h0);
    m_pc = 32'h0;
    m_instret = 32'h0;

    for (int k = 0; k < 20; k++) begin
      logic tk;
      int   iw, dw;
      r    = $urandom;
      insn = {r[31:7], ops[$urandom_range(0, 10)]};
      alu  = $urandom;
      tk   = 1'($urandom_range(0, 1));
      iw   = $urandom_range(0, 2);
      dw   = $urandom_range(0, 2);
      e    = model(m_pc, insn, alu, tk, iw, dw);
      run_insn(insn, alu, tk, iw, dw, o);
      m_instret += 32'(e.ret);
      check_obs("post", k, insn, e, o);
      m_pc = e.npc;
    end

    finish_run();
  end

endmodule
`default_nettype wire
